sccb_responder: RTL and testbench
=================================

Name: sccb_responder

Overview:
- Synthesizable SCCB (3-wire-subset, 2-wire) responder. It models the OV7670 register interface seen by our SCCB initiator inside the camera front-end.
- Used as an on-FPGA loopback target: SCCB init sequences can be brought up, and PS-driven register accesses checked, with no sensor fitted.
- Samples SIOC/SIOD against sysclk. Holds an internal 256x8 register file. Drives SIOD open-drain for ACK and read data.

Parameters:
- DEV_ID, 8'h42: write address. Bit0 is ignored on match; read address is DEV_ID|1.
- PID_VALUE, 8'h76: read-only value at sub-address 0x0A.
- VER_VALUE, 8'h73: read-only value at sub-address 0x0B.
- SYNC_STAGES, 2: synchronizer depth for SIOC/SIOD, minimum 2.

Ports:
- sysclk  in  1  sole clock; SIOC period must be >= 8 sysclk cycles.
- n_rst  in  1  asynchronous, active-low reset.
- sioc  in  1  SCCB clock from the initiator.
- siod_i  in  1  SIOD pad input.
- siod_oe  out  1  1 = pull SIOD low; 0 = release (pad pulled high). The pad output is tied 0.
- wr_valid  out  1  one-cycle pulse when a register write commits.
- wr_addr  out  8  sub-address of the committed write.
- wr_data  out  8  data of the committed write.
- busy  out  1  high from START to STOP.
- dbg_addr  in  8  asynchronous debug read address.
- dbg_data  out  8  register file contents at dbg_addr, combinational.

Behaviour:
- Reset values: siod_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, state=IDLE. Register file = defaults: all 0x00 except 0x0A=PID_VALUE and 0x0B=VER_VALUE.
- Asserting n_rst mid-transaction releases SIOD immediately.
- SIOC and SIOD pass through SYNC_STAGES flops, then a 1-cycle edge detector. All events lag the pins by SYNC_STAGES+1 cycles.
- Line events:
  - START: SIOD falls while SIOC is high.
  - STOP: SIOD rises while SIOC is high.
  - Bits are sampled on SIOC rise.
  - siod_oe changes only on a detected SIOC fall.
- STOP from any state: release siod_oe, busy=0, go to IDLE.
- START from any state, including repeated start: busy=1, go to ID with bit_cnt cleared. The sub-address pointer is retained.
- States: IDLE, ID, ID_ACK, SUBADDR, SUBADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE.
- ID: shift 8 bits MSB first.
  - On the 8th SIOC fall, if byte[7:1]==DEV_ID[7:1]: assert siod_oe and go to ID_ACK, recording rw=byte[0].
  - Otherwise go to IGNORE.
- ID_ACK: on the next SIOC fall, release.
  - rw=0 goes to SUBADDR.
  - rw=1 loads shift_reg from the register at the pointer and drives bit7 (oe = ~bit) in the same cycle, then goes to RDATA.
- SUBADDR: 8 bits form the pointer. ACK as in ID_ACK, then go to WDATA.
  - A STOP here (2-phase write) leaves the pointer set, for a following read.
- WDATA: capture 8 bits, then ACK.
  - On the 8th SIOC rise +1 cycle: wr_valid pulses and wr_addr/wr_data update.
  - The register file is written in the same cycle, unless the pointer is 0x0A or 0x0B (read-only; wr_valid still pulses).
  - Writing 0x12 with bit7=1 resets the whole register file to defaults in that cycle. 0x12 then reads 0x00.
- WDATA_ACK, then any further bytes: go to IGNORE. No auto-increment and no ACK.
- RDATA:
  - Each SIOC fall shifts out the next bit.
  - After bit0's high phase, the next fall releases SIOD and enters RD_NA.
  - The initiator's NA/ACK bit is sampled and ignored.
  - Then go to IGNORE. The pointer does not increment.
- IGNORE: siod_oe=0 and wait for STOP/START.
- Simultaneous START/STOP with a SIOC edge in the same sysclk cycle: the line event wins.

Decomposition:
- Package sccb_pkg:
  - state_t enum.
  - Constants REG_PID=8'h0A, REG_VER=8'h0B, REG_COM7=8'h12, COM7_RESET_BIT=7.
  - Default-value function for register initialisation.
- Sub-module sccb_line_sync: synchronizers plus detection of sioc_rise, sioc_fall, start and stop. About 50 lines.

Test Plan:
- 3-phase write 0x42/0x12/0x04 at SIOC=100kHz, sysclk 125MHz:
  - ACK (siod_oe=1) in all three 9th-bit slots.
  - One wr_valid with wr_addr=0x12 and wr_data=0x04.
  - dbg_data@0x12 = 0x04.
- 2-phase write 0x42/0x0A, STOP, then 0x43 read: returned byte 0x76; no wr_valid.
- Write 0x42/0x0B/0x55 (read-only): wr_valid pulses, but the following read of 0x0B returns 0x73.
- Write 0x12=0x80 after a prior 0x3A=0x0C write: dbg_data@0x3A = 0x00 and dbg_data@0x12 = 0x00.
- ID 0x60 (mismatch): siod_oe stays 0 throughout. A following valid transaction succeeds.
- Error conditions:
  - Assert n_rst low during RDATA while driving 0: siod_oe=0 within the same cycle and busy=0.
  - Repeated START mid-WDATA: no wr_valid, and the new transaction is decoded normally.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
`timescale 1ns/1ps
package sccb_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StId,
      StIdAck,
      StSubaddr,
      StSubaddrAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRdNa,
      StIgnore
   } state_t;

   localparam logic [7:0]  REG_PID        = 8'h0A;
   localparam logic [7:0]  REG_VER        = 8'h0B;
   localparam logic [7:0]  REG_COM7       = 8'h12;
   localparam int unsigned COM7_RESET_BIT = 7;

   function automatic logic [7:0] reg_default(input logic [7:0] addr,
                                              input logic [7:0] pid,
                                              input logic [7:0] ver);
      logic [7:0] val;
      case (addr)
         REG_PID: val = pid;
         REG_VER: val = ver;
         default: val = 8'h00;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises SIOC/SIOD to sysclk and detects clock edges and START/STOP.
`timescale 1ns/1ps
module sccb_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic sysclk,
   input  logic n_rst,
   input  logic sioc,
   input  logic siod_i,
   output logic siod_bit,
   output logic sioc_rise,
   output logic sioc_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] sioc_sync;
   logic [SYNC_STAGES-1:0] siod_sync;
   logic                   sioc_prev;
   logic                   siod_prev;
   logic                   sioc_s;
   logic                   siod_s;
   logic                   sioc_high;

   // Idle bus is high on both lines; reset there so no spurious events appear.
   always_ff @(posedge sysclk or negedge n_rst) begin
      if (!n_rst) begin
         sioc_sync <= '1;
         siod_sync <= '1;
         sioc_prev <= 1'b1;
         siod_prev <= 1'b1;
      end else begin
         sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
         siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod_i};
         sioc_prev <= sioc_s;
         siod_prev <= siod_s;
      end
   end

   assign sioc_s    = sioc_sync[SYNC_STAGES-1];
   assign siod_s    = siod_sync[SYNC_STAGES-1];
   assign siod_bit  = siod_s;
   assign sioc_rise = sioc_s & ~sioc_prev;
   assign sioc_fall = ~sioc_s & sioc_prev;
   // Either sample high counts, so a line event coincident with a SIOC edge is still seen.
   assign sioc_high = sioc_s | sioc_prev;
   assign start     = sioc_high & siod_prev & ~siod_s;
   assign stop      = sioc_high & ~siod_prev & siod_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB responder modelling an OV7670 register file as a loopback target.
`timescale 1ns/1ps
module sccb_responder
   import sccb_pkg::*;
#(
   parameter logic [7:0]  DEV_ID      = 8'h42,
   parameter logic [7:0]  PID_VALUE   = 8'h76,
   parameter logic [7:0]  VER_VALUE   = 8'h73,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       sysclk,
   input  logic       n_rst,
   input  logic       sioc,
   input  logic       siod_i,
   output logic       siod_oe,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   logic       siod_bit, sioc_rise, sioc_fall, start, stop;
   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d, ptr_q, ptr_d;
   logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
   logic       rw_q, rw_d, oe_q, oe_d, busy_q, busy_d, wr_valid_q, wr_valid_d;
   logic       reg_we, reg_clear;
   logic [7:0] regs [256];
   logic [7:0] rd_byte, in_byte;

   sccb_line_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_line_sync (
      .sysclk   (sysclk),
      .n_rst    (n_rst),
      .sioc     (sioc),
      .siod_i   (siod_i),
      .siod_bit (siod_bit),
      .sioc_rise(sioc_rise),
      .sioc_fall(sioc_fall),
      .start    (start),
      .stop     (stop)
   );

   assign rd_byte = regs[ptr_q];
   assign in_byte = {shift_q[6:0], siod_bit};

   always_ff @(posedge sysclk or negedge n_rst) begin
      if (!n_rst) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = StIdle;
      end else if (start) begin
         state_d = StId;
      end else begin
         case (state_q)
            StId: if (sioc_fall && bit_cnt_q == 4'd8)
               state_d = (shift_q[7:1] == DEV_ID[7:1]) ? StIdAck : StIgnore;
            StIdAck:      if (sioc_fall) state_d = rw_q ? StRdata : StSubaddr;
            StSubaddr:    if (sioc_fall && bit_cnt_q == 4'd8) state_d = StSubaddrAck;
            StSubaddrAck: if (sioc_fall) state_d = StWdata;
            StWdata:      if (sioc_fall && bit_cnt_q == 4'd8) state_d = StWdataAck;
            StWdataAck:   if (sioc_fall) state_d = StIgnore;
            StRdata:      if (sioc_fall && bit_cnt_q == 4'd8) state_d = StRdNa;
            StRdNa:       if (sioc_rise) state_d = StIgnore;
            default:      state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      reg_we     = 1'b0;
      reg_clear  = 1'b0;
      if (stop) begin
         oe_d   = 1'b0;
         busy_d = 1'b0;
      end else if (start) begin
         oe_d      = 1'b0;
         busy_d    = 1'b1;
         bit_cnt_d = 4'd0;
      end else begin
         if ((state_q == StId || state_q == StSubaddr || state_q == StWdata) &&
             sioc_rise && bit_cnt_q != 4'd8) begin
            shift_d   = in_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
         case (state_q)
            StId: if (sioc_fall && bit_cnt_q == 4'd8 && shift_q[7:1] == DEV_ID[7:1]) begin
               oe_d = 1'b1;
               rw_d = shift_q[0];
            end
            StIdAck: if (sioc_fall) begin
               bit_cnt_d = 4'd0;
               oe_d      = 1'b0;
               if (rw_q) begin
                  shift_d   = rd_byte;
                  oe_d      = ~rd_byte[7];
                  bit_cnt_d = 4'd1;
               end
            end
            StSubaddr: if (sioc_fall && bit_cnt_q == 4'd8) begin
               ptr_d = shift_q;
               oe_d  = 1'b1;
            end
            StSubaddrAck: if (sioc_fall) begin
               oe_d      = 1'b0;
               bit_cnt_d = 4'd0;
            end
            StWdata: begin
               if (sioc_rise && bit_cnt_q == 4'd7) begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = in_byte;
                  if (ptr_q == REG_COM7 && in_byte[COM7_RESET_BIT]) reg_clear = 1'b1;
                  else if (ptr_q != REG_PID && ptr_q != REG_VER)     reg_we    = 1'b1;
               end
               if (sioc_fall && bit_cnt_q == 4'd8) oe_d = 1'b1;
            end
            StWdataAck: if (sioc_fall) oe_d = 1'b0;
            StRdata: if (sioc_fall) begin
               if (bit_cnt_q == 4'd8) begin
                  oe_d = 1'b0;
               end else begin
                  oe_d      = ~shift_q[6];
                  shift_d   = {shift_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            StIgnore: oe_d = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge n_rst) begin
      if (!n_rst) begin
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         ptr_q      <= 8'h00;
         rw_q       <= 1'b0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 8'h00;
         wr_data_q  <= 8'h00;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   always_ff @(posedge sysclk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < 256; i++) regs[i] <= reg_default(8'(i), PID_VALUE, VER_VALUE);
      end else if (reg_clear) begin
         for (int i = 0; i < 256; i++) regs[i] <= reg_default(8'(i), PID_VALUE, VER_VALUE);
      end else if (reg_we) begin
         regs[ptr_q] <= in_byte;
      end
   end

   assign siod_oe  = oe_q;
   assign busy     = busy_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: an open-drain SCCB initiator model drives the bus.
`timescale 1ns/1ps
module tb_sccb_responder;

   logic       sysclk = 1'b0;
   logic       n_rst  = 1'b0;
   logic       scl    = 1'b1;
   logic       sda    = 1'b1;
   logic       sioc, siod_i, siod_oe, wr_valid, busy;
   logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

   int         errors  = 0;
   int         checks  = 0;
   int         quarter = 8;
   int         wr_cnt  = 0;
   int         oe_cycles = 0;
   logic [7:0] last_addr = 8'h00;
   logic [7:0] last_data = 8'h00;

   assign sioc   = scl;
   assign siod_i = sda & ~siod_oe;

   sccb_responder dut (
      .sysclk  (sysclk),
      .n_rst   (n_rst),
      .sioc    (sioc),
      .siod_i  (siod_i),
      .siod_oe (siod_oe),
      .wr_valid(wr_valid),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   always #4 sysclk = ~sysclk;

   always @(posedge sysclk) begin
      if (wr_valid) begin
         wr_cnt    <= wr_cnt + 1;
         last_addr <= wr_addr;
         last_data <= wr_data;
      end
      if (siod_oe) oe_cycles <= oe_cycles + 1;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_q();
      repeat (quarter) @(negedge sysclk);
   endtask

   task automatic bus_start();
      sda = 1'b1; wait_q();
      scl = 1'b1; wait_q();
      sda = 1'b0; wait_q();
      scl = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda = 1'b0; wait_q();
      scl = 1'b1; wait_q();
      sda = 1'b1; wait_q();
   endtask

   task automatic send_bit(input logic b);
      sda = b;    wait_q();
      scl = 1'b1; wait_q(); wait_q();
      scl = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda = 1'b1; wait_q();
      scl = 1'b1; wait_q();
      ack = siod_oe;
      wait_q();
      scl = 1'b0; wait_q();
   endtask

   task automatic read_byte(output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         sda = 1'b1; wait_q();
         scl = 1'b1; wait_q();
         d[i] = siod_i;
         wait_q();
         scl = 1'b0; wait_q();
      end
      send_bit(1'b1);
   endtask

   task automatic write3(input logic [7:0] sub, input logic [7:0] dat,
                         output logic a0, output logic a1, output logic a2);
      bus_start();
      send_byte(8'h42, a0);
      send_byte(sub, a1);
      send_byte(dat, a2);
      bus_stop();
   endtask

   task automatic read2(input logic [7:0] sub, output logic a0, output logic a1,
                        output logic a2, output logic [7:0] d);
      bus_start();
      send_byte(8'h42, a0);
      send_byte(sub, a1);
      bus_stop();
      bus_start();
      send_byte(8'h43, a2);
      read_byte(d);
      bus_stop();
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(negedge sysclk);
      checks += 5;
      if (siod_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", siod_oe); end
      if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
      if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
      if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      dbg_addr = 8'h0A; #1; checks++;
      if (dbg_data !== 8'h76) begin errors++; $display("FAIL reset_pid: got %h expected 76", dbg_data); end
      dbg_addr = 8'h0B; #1; checks++;
      if (dbg_data !== 8'h73) begin errors++; $display("FAIL reset_ver: got %h expected 73", dbg_data); end
      dbg_addr = 8'h12; #1; checks++;
      if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_com7: got %h expected 00", dbg_data); end
      @(negedge sysclk);
      n_rst = 1'b1;
      repeat (5) @(negedge sysclk);
   endtask

   task automatic test_write3_100k();
      logic a0, a1, a2;
      int   w0;
      quarter = 313;
      w0 = wr_cnt;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      send_byte(8'h04, a2);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL w3_busy_mid: got %b expected 1", busy); end
      bus_stop();
      repeat (5) @(negedge sysclk);
      checks += 7;
      if (a0 !== 1'b1) begin errors++; $display("FAIL w3_ack_id: got %b expected 1", a0); end
      if (a1 !== 1'b1) begin errors++; $display("FAIL w3_ack_sub: got %b expected 1", a1); end
      if (a2 !== 1'b1) begin errors++; $display("FAIL w3_ack_data: got %b expected 1", a2); end
      if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL w3_wr_count: got %0d expected 1", wr_cnt - w0); end
      if (last_addr !== 8'h12) begin errors++; $display("FAIL w3_wr_addr: got %h expected 12", last_addr); end
      if (last_data !== 8'h04) begin errors++; $display("FAIL w3_wr_data: got %h expected 04", last_data); end
      if (busy !== 1'b0) begin errors++; $display("FAIL w3_busy_end: got %b expected 0", busy); end
      dbg_addr = 8'h12; #1; checks++;
      if (dbg_data !== 8'h04) begin errors++; $display("FAIL w3_dbg: got %h expected 04", dbg_data); end
      quarter = 8;
   endtask

   task automatic test_read_pid();
      logic a0, a1, a2;
      logic [7:0] d;
      int   w0;
      w0 = wr_cnt;
      read2(8'h0A, a0, a1, a2, d);
      repeat (5) @(negedge sysclk);
      checks += 3;
      if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL pid_acks: got %b expected 111", {a0, a1, a2}); end
      if (d !== 8'h76) begin errors++; $display("FAIL pid_data: got %h expected 76", d); end
      if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL pid_no_write: got %0d expected 0", wr_cnt - w0); end
   endtask

   task automatic test_readonly();
      logic a0, a1, a2;
      logic [7:0] d;
      int   w0;
      w0 = wr_cnt;
      write3(8'h0B, 8'h55, a0, a1, a2);
      repeat (5) @(negedge sysclk);
      checks += 4;
      if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL ro_acks: got %b expected 111", {a0, a1, a2}); end
      if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL ro_wr_count: got %0d expected 1", wr_cnt - w0); end
      if (last_addr !== 8'h0B) begin errors++; $display("FAIL ro_wr_addr: got %h expected 0b", last_addr); end
      if (last_data !== 8'h55) begin errors++; $display("FAIL ro_wr_data: got %h expected 55", last_data); end
      read2(8'h0B, a0, a1, a2, d);
      checks++;
      if (d !== 8'h73) begin errors++; $display("FAIL ro_readback: got %h expected 73", d); end
   endtask

   task automatic test_com7_reset();
      logic a0, a1, a2;
      int   w0;
      write3(8'h3A, 8'h0C, a0, a1, a2);
      dbg_addr = 8'h3A; #1; checks++;
      if (dbg_data !== 8'h0C) begin errors++; $display("FAIL com7_pre: got %h expected 0c", dbg_data); end
      w0 = wr_cnt;
      write3(8'h12, 8'h80, a0, a1, a2);
      repeat (5) @(negedge sysclk);
      checks++;
      if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL com7_wr_count: got %0d expected 1", wr_cnt - w0); end
      dbg_addr = 8'h3A; #1; checks++;
      if (dbg_data !== 8'h00) begin errors++; $display("FAIL com7_3a: got %h expected 00", dbg_data); end
      dbg_addr = 8'h12; #1; checks++;
      if (dbg_data !== 8'h00) begin errors++; $display("FAIL com7_12: got %h expected 00", dbg_data); end
      dbg_addr = 8'h0A; #1; checks++;
      if (dbg_data !== 8'h76) begin errors++; $display("FAIL com7_pid: got %h expected 76", dbg_data); end
   endtask

   task automatic test_mismatch();
      logic a0, a1, a2;
      int   oe0;
      oe0 = oe_cycles;
      bus_start();
      send_byte(8'h60, a0);
      send_byte(8'h20, a1);
      bus_stop();
      repeat (5) @(negedge sysclk);
      checks += 2;
      if (a0 !== 1'b0) begin errors++; $display("FAIL mm_ack: got %b expected 0", a0); end
      if (oe_cycles - oe0 !== 0) begin errors++; $display("FAIL mm_oe_cycles: got %0d expected 0", oe_cycles - oe0); end
      write3(8'h20, 8'h5A, a0, a1, a2);
      checks++;
      if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL mm_next_acks: got %b expected 111", {a0, a1, a2}); end
      dbg_addr = 8'h20; #1; checks++;
      if (dbg_data !== 8'h5A) begin errors++; $display("FAIL mm_next_data: got %h expected 5a", dbg_data); end
   endtask

   task automatic test_reset_rdata();
      logic a0, a1;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h30, a1);
      bus_stop();
      bus_start();
      send_byte(8'h43, a0);
      sda = 1'b1; wait_q();
      scl = 1'b1; wait_q();
      checks++;
      if (siod_oe !== 1'b1) begin errors++; $display("FAIL rst_rd_driving: got %b expected 1", siod_oe); end
      n_rst = 1'b0;
      #1;
      checks += 2;
      if (siod_oe !== 1'b0) begin errors++; $display("FAIL rst_rd_oe: got %b expected 0", siod_oe); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_rd_busy: got %b expected 0", busy); end
      scl = 1'b1; sda = 1'b1;
      repeat (5) @(negedge sysclk);
      n_rst = 1'b1;
      repeat (5) @(negedge sysclk);
      dbg_addr = 8'h20; #1; checks++;
      if (dbg_data !== 8'h00) begin errors++; $display("FAIL rst_rd_regs: got %h expected 00", dbg_data); end
   endtask

   task automatic test_repeated_start();
      logic a0, a1, a2;
      int   w0;
      w0 = wr_cnt;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h25, a1);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h26, a1);
      send_byte(8'h99, a2);
      bus_stop();
      repeat (5) @(negedge sysclk);
      checks += 4;
      if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rs_acks: got %b expected 111", {a0, a1, a2}); end
      if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL rs_wr_count: got %0d expected 1", wr_cnt - w0); end
      if (last_addr !== 8'h26) begin errors++; $display("FAIL rs_wr_addr: got %h expected 26", last_addr); end
      if (last_data !== 8'h99) begin errors++; $display("FAIL rs_wr_data: got %h expected 99", last_data); end
      dbg_addr = 8'h25; #1; checks++;
      if (dbg_data !== 8'h00) begin errors++; $display("FAIL rs_aborted: got %h expected 00", dbg_data); end
      dbg_addr = 8'h26; #1; checks++;
      if (dbg_data !== 8'h99) begin errors++; $display("FAIL rs_new: got %h expected 99", dbg_data); end
   endtask

   initial begin
      dbg_addr = 8'h00;
      test_reset();
      test_write3_100k();
      test_read_pid();
      test_readonly();
      test_com7_reset();
      test_mismatch();
      test_reset_rdata();
      test_repeated_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
